instr_encoder: RTL and testbench
================================

Name: instr_encoder

Overview:
- Pipelined RV32I instruction encoder: the writer-side counterpart of the control decoder.
- Accepts a mnemonic code plus register and immediate fields, and emits the packed 32-bit instruction word.
- Covers exactly the instruction set the CPU decodes.
- Used by the self-test program generator and boot loader to fill instruction memory; sits between the test sequencer and the IM write port.

Parameters:
- CNT_W, 16, width of the emitted-instruction counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  request valid.
- in_ready  out  1  encoder can accept a request.
- in_mnem  in  5  mnemonic code (package enum, 0..30).
- in_rd  in  5  destination register.
- in_rs1  in  5  source register 1.
- in_rs2  in  5  source register 2.
- in_imm  in  32  signed immediate, or shamt; lui takes upper 20 bits in in_imm[19:0].
- out_valid  out  1  out_instr valid.
- out_ready  in  1  downstream accepts.
- out_instr  out  32  packed instruction.
- out_err  out  1  request was illegal or its immediate was out of range; qualified by out_valid.
- instr_cnt  out  CNT_W  count of out_valid & out_ready handshakes.

Behaviour:
- Reset: out_valid=0, out_instr=0, out_err=0, instr_cnt=0, both pipeline stages empty. in_ready=1 in the cycle after rst deasserts.
- Reset mid-operation drops all in-flight requests without emitting them.
- Pipeline, 2 stages:
  - S1 registers the fields and classifies format (R/I/S/B/U/J) and range.
  - S2 packs the word and drives the outputs.
  - Latency: 2 cycles, in-handshake to out_valid. Throughput: 1 per cycle.
- Handshake:
  - A transfer occurs when valid & ready are both high.
  - in_ready = ~s1_valid | (~s2_valid | out_ready).
  - S2 loads when empty or its output is consumed; under stall both stages hold.
  - Outputs stay stable while out_valid & ~out_ready.
  - An input transfer and an output transfer in the same cycle are allowed; with both stages full and out_ready=1 there is no bubble.
- Format fields:
  - R: funct7 0x00, or 0x20 for sub/sra.
  - I: imm[11:0]. Shifts: shamt=in_imm[4:0], funct7 0x20 for srai.
  - S: imm[11:5] | imm[4:0].
  - B: imm[12|10:5] and imm[4:1|11].
  - U: in_imm[19:0] placed at [31:12].
  - J: imm[20|10:1|11|19:12].
- Opcodes:
  - lui 0110111, jal 1101111, jalr 1100111, branch 1100011, load 0000011, store 0100011, op-imm 0010011, op 0110011.
  - lw/sw use funct3 010; branch funct3 follows the standard table.
- Fields unused by a format are ignored: rd for S/B, rs2 for I.
- Range rules (macro on):
  - I and S: −2048..2047.
  - Shifts: 0..31.
  - B: −4096..4094, even.
  - J: −1048576..1048574, even.
  - U: in_imm[31:20]=0.
  - Mnemonic code >30 is illegal.
  - Violation: out_err=1 and out_instr=0x00000013 (nop). The counter still increments.
- instr_cnt wraps from all-ones to 0.

Optional Feature:
- Macro: INSTR_ENC_RANGE_CHECK_EN.
- Defined: range and illegal checks exactly as above.
- Undefined:
  - out_err is tied to 0 and no checks are performed.
  - Immediates are truncated to the field bits; odd B/J offsets drop bit 0.
  - Mnemonic code >30 emits 0x00000013.

Decomposition:
- Package instr_enc_pkg holds:
  - mnemonic enum (5-bit);
  - opcode localparams;
  - funct3/funct7 constants;
  - format enum (R, I, S, B, U, J);
  - NOP constant 0x00000013.
- One sub-module, instr_enc_pack: combinational S2 packer taking format, fields and immediate, producing the 32-bit word.
- Handshake, range check and counter stay in instr_encoder.

Test Plan:
- addi x1,x0,5 -> 0x00500093 two cycles after accept; instr_cnt=1.
- add x3,x1,x2, then srai x4,x4,3, back-to-back -> 0x002081B3, then 0x40325213, on consecutive cycles.
- sw x2,8(x1) -> 0x0020A423. beq x1,x2,−4 -> 0xFE208EE3.
- jal x1,2048 -> 0x001000EF. lui x5,0x12345 -> 0x123452B7.
- addi with imm=4096 (macro on) -> out_err=1, out_instr=0x00000013. Macro off -> out_err=0, word 0x00000093.
- Stall and reset:
  - Hold out_ready=0 for 5 cycles with 3 requests offered -> 2 accepted, in_ready=0, out_instr stable.
  - Release -> both emitted in order.
  - Assert rst mid-stream -> out_valid=0 next cycle, instr_cnt=0.

Source files
------------

// File: rtl/instr_enc_pkg.sv
// Shared types and encodings for the RV32I instruction encoder: mnemonic codes,
// instruction formats, opcode/funct constants and the mnemonic decode helper.
package instr_enc_pkg;

    typedef enum logic [4:0] {
        MN_ADD, MN_SUB, MN_SLL, MN_SLT, MN_SLTU, MN_XOR, MN_SRL, MN_SRA, MN_OR, MN_AND,
        MN_ADDI, MN_SLTI, MN_SLTIU, MN_XORI, MN_ORI, MN_ANDI, MN_SLLI, MN_SRLI, MN_SRAI,
        MN_LW, MN_SW, MN_BEQ, MN_BNE, MN_BLT, MN_BGE, MN_BLTU, MN_BGEU,
        MN_JAL, MN_JALR, MN_LUI, MN_NOP
    } mnem_e;

    typedef enum logic [2:0] {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J} fmt_e;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    localparam logic [2:0] F3_000 = 3'b000;
    localparam logic [2:0] F3_001 = 3'b001;
    localparam logic [2:0] F3_010 = 3'b010;
    localparam logic [2:0] F3_011 = 3'b011;
    localparam logic [2:0] F3_100 = 3'b100;
    localparam logic [2:0] F3_101 = 3'b101;
    localparam logic [2:0] F3_110 = 3'b110;
    localparam logic [2:0] F3_111 = 3'b111;

    localparam logic [6:0] F7_BASE = 7'h00;
    localparam logic [6:0] F7_ALT  = 7'h20;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        fmt_e       fmt;
        logic [6:0] opcode;
        logic [2:0] funct3;
        logic [6:0] funct7;
        logic       is_shift;
        logic       is_nop;
        logic       legal;
    } dec_t;

    function automatic dec_t decode_mnem(input logic [4:0] m);
        dec_t d;
        d = '0;
        d.legal = 1'b1;
        case (m)
            MN_ADD, MN_SUB, MN_SLL, MN_SLT, MN_SLTU,
            MN_XOR, MN_SRL, MN_SRA, MN_OR, MN_AND:         begin d.fmt = FMT_R; d.opcode = OP_REG; end
            MN_ADDI, MN_SLTI, MN_SLTIU, MN_XORI, MN_ORI,
            MN_ANDI, MN_SLLI, MN_SRLI, MN_SRAI, MN_NOP:    begin d.fmt = FMT_I; d.opcode = OP_IMM; end
            MN_LW:                                         begin d.fmt = FMT_I; d.opcode = OP_LOAD; end
            MN_JALR:                                       begin d.fmt = FMT_I; d.opcode = OP_JALR; end
            MN_SW:                                         begin d.fmt = FMT_S; d.opcode = OP_STORE; end
            MN_BEQ, MN_BNE, MN_BLT, MN_BGE, MN_BLTU,
            MN_BGEU:                                       begin d.fmt = FMT_B; d.opcode = OP_BRANCH; end
            MN_JAL:                                        begin d.fmt = FMT_J; d.opcode = OP_JAL; end
            MN_LUI:                                        begin d.fmt = FMT_U; d.opcode = OP_LUI; end
            default:                                       begin d.legal = 1'b0; d.is_nop = 1'b1; end
        endcase
        case (m)
            MN_SLL, MN_SLLI, MN_BNE:                   d.funct3 = F3_001;
            MN_SLT, MN_SLTI, MN_LW, MN_SW:             d.funct3 = F3_010;
            MN_SLTU, MN_SLTIU:                         d.funct3 = F3_011;
            MN_XOR, MN_XORI, MN_BLT:                   d.funct3 = F3_100;
            MN_SRL, MN_SRA, MN_SRLI, MN_SRAI, MN_BGE:  d.funct3 = F3_101;
            MN_OR, MN_ORI, MN_BLTU:                    d.funct3 = F3_110;
            MN_AND, MN_ANDI, MN_BGEU:                  d.funct3 = F3_111;
            default:                                   d.funct3 = F3_000;
        endcase
        d.funct7   = (m == MN_SUB || m == MN_SRA || m == MN_SRAI) ? F7_ALT : F7_BASE;
        d.is_shift = (m == MN_SLLI || m == MN_SRLI || m == MN_SRAI);
        if (m == MN_NOP) d.is_nop = 1'b1;
        return d;
    endfunction

endpackage

// File: rtl/instr_enc_pack.sv
// Combinational second-stage packer: scatters registered fields and immediate
// bits into the 32-bit RV32I word for the given format.
module instr_enc_pack
    import instr_enc_pkg::*;
(
    input  fmt_e        fmt,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic        is_shift,
    input  logic        nop,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [20:0] imm,
    output logic [31:0] word
);

    always_comb begin
        word = NOP_INSTR;
        case (fmt)
            FMT_R: word = {funct7, rs2, rs1, funct3, rd, opcode};
            FMT_I: word = is_shift ? {funct7, imm[4:0], rs1, funct3, rd, opcode}
                                   : {imm[11:0], rs1, funct3, rd, opcode};
            FMT_S: word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
            FMT_B: word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
            FMT_U: word = {imm[19:0], rd, opcode};
            FMT_J: word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
            default: word = NOP_INSTR;
        endcase
        if (nop) word = NOP_INSTR;
    end

endmodule

// File: rtl/instr_encoder.sv
// Two-stage pipelined RV32I instruction encoder with valid/ready handshake.
// Define INSTR_ENC_RANGE_CHECK_EN to enable immediate range and illegal-mnemonic checks.
module instr_encoder
    import instr_enc_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       in_mnem,
    input  logic [4:0]       in_rd,
    input  logic [4:0]       in_rs1,
    input  logic [4:0]       in_rs2,
    input  logic [31:0]      in_imm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_instr,
    output logic             out_err,
    output logic [CNT_W-1:0] instr_cnt
);

    dec_t        dec;
    logic        err_c;
    logic [2:1]  vld_pipe;
    logic        s2_load;
    logic [31:0] pack_word;

    fmt_e        s1_fmt;
    logic [6:0]  s1_op, s1_f7;
    logic [2:0]  s1_f3;
    logic        s1_shift, s1_nop, s1_err;
    logic [4:0]  s1_rd, s1_rs1, s1_rs2;
    logic [20:0] s1_imm;

    assign dec = decode_mnem(in_mnem);

`ifdef INSTR_ENC_RANGE_CHECK_EN
    logic signed [31:0] imm_s;
    logic               range_err;

    assign imm_s = in_imm;

    always_comb begin
        range_err = 1'b0;
        case (dec.fmt)
            FMT_I: range_err = dec.is_shift ? (in_imm[31:5] != '0) : (imm_s < -2048 || imm_s > 2047);
            FMT_S: range_err = (imm_s < -2048 || imm_s > 2047);
            FMT_B: range_err = (imm_s < -4096 || imm_s > 4094 || in_imm[0]);
            FMT_J: range_err = (imm_s < -1048576 || imm_s > 1048574 || in_imm[0]);
            FMT_U: range_err = (in_imm[31:20] != '0);
            default: range_err = 1'b0;
        endcase
    end

    // The nop mnemonic carries no immediate, so its imm field is never range-checked.
    assign err_c = ~dec.legal | (range_err & ~dec.is_nop);
`else
    logic unused_chk;
    assign unused_chk = ^{in_imm[31:21], dec.legal};
    assign err_c      = 1'b0;
`endif

    // Stage 2 frees up when empty or drained; stage 1 accepts whenever it can move on.
    assign s2_load   = ~vld_pipe[2] | out_ready;
    assign in_ready  = ~vld_pipe[1] | s2_load;
    assign out_valid = vld_pipe[2];

    instr_enc_pack u_pack (
        .fmt      (s1_fmt),
        .opcode   (s1_op),
        .funct3   (s1_f3),
        .funct7   (s1_f7),
        .is_shift (s1_shift),
        .nop      (s1_nop),
        .rd       (s1_rd),
        .rs1      (s1_rs1),
        .rs2      (s1_rs2),
        .imm      (s1_imm),
        .word     (pack_word)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe  <= '0;
            out_instr <= '0;
            out_err   <= 1'b0;
            instr_cnt <= '0;
            s1_fmt    <= FMT_R;
            s1_op     <= '0;
            s1_f3     <= '0;
            s1_f7     <= '0;
            s1_shift  <= 1'b0;
            s1_nop    <= 1'b0;
            s1_err    <= 1'b0;
            s1_rd     <= '0;
            s1_rs1    <= '0;
            s1_rs2    <= '0;
            s1_imm    <= '0;
        end else begin
            if (out_valid && out_ready) instr_cnt <= instr_cnt + 1'b1;
            if (s2_load) begin
                vld_pipe[2] <= vld_pipe[1];
                if (vld_pipe[1]) begin
                    out_instr <= pack_word;
                    out_err   <= s1_err;
                end
            end
            if (in_ready) begin
                vld_pipe[1] <= in_valid;
                if (in_valid) begin
                    s1_fmt   <= dec.fmt;
                    s1_op    <= dec.opcode;
                    s1_f3    <= dec.funct3;
                    s1_f7    <= dec.funct7;
                    s1_shift <= dec.is_shift;
                    s1_nop   <= dec.is_nop | err_c;
                    s1_err   <= err_c;
                    s1_rd    <= in_rd;
                    s1_rs1   <= in_rs1;
                    s1_rs2   <= in_rs2;
                    s1_imm   <= in_imm[20:0];
                end
            end
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: directed vectors plus randomized traffic
// checked against an arithmetic reference model of the RV32I encodings.
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  in_mnem = '0, in_rd = '0, in_rs1 = '0, in_rs2 = '0;
    logic [31:0] in_imm = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_instr;
    logic        out_err;
    logic [15:0] instr_cnt;

    always #5 clk = ~clk;

    instr_encoder #(.CNT_W(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_mnem(in_mnem), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_err(out_err), .instr_cnt(instr_cnt)
    );

`ifdef INSTR_ENC_RANGE_CHECK_EN
    localparam bit RC = 1'b1;
`else
    localparam bit RC = 1'b0;
`endif

    typedef struct { logic [31:0] w; logic e; } exp_t;
    exp_t        q[$];
    int          tests = 0, fails = 0;
    logic [15:0] mcnt = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // Reference model: mnemonic numbering 0..9 R-type, 10..15 op-imm, 16..18 shifts,
    // 19 lw, 20 sw, 21..26 branches, 27 jal, 28 jalr, 29 lui, 30 nop, 31 illegal.
    function automatic void model(input int mn, input logic [4:0] rd, rs1, rs2,
                                  input logic [31:0] imm, output logic [31:0] w, output logic e);
        int f3r[10] = '{0, 0, 1, 2, 3, 4, 5, 5, 6, 7};
        int f3i[6]  = '{0, 2, 3, 4, 6, 7};
        int f3b[6]  = '{0, 1, 4, 5, 6, 7};
        int si;
        logic [31:0] u, rdv, r1, r2;
        bit bad;
        si = $signed(imm); u = imm; bad = 0;
        rdv = 32'(rd) << 7; r1 = 32'(rs1) << 15; r2 = 32'(rs2) << 20;
        if (mn <= 9) begin
            w = ((mn == 1 || mn == 7) ? 32'h4000_0000 : 32'h0) | r2 | r1 | (32'(f3r[mn]) << 12) | rdv | 32'h33;
        end else if (mn <= 15 || mn == 19 || mn == 28) begin
            int f3; logic [31:0] op;
            f3 = (mn == 19) ? 2 : (mn == 28) ? 0 : f3i[mn-10];
            op = (mn == 19) ? 32'h03 : (mn == 28) ? 32'h67 : 32'h13;
            bad = si < -2048 || si > 2047;
            w = ((u & 32'hfff) << 20) | r1 | (32'(f3) << 12) | rdv | op;
        end else if (mn <= 18) begin
            bad = u > 31;
            w = ((mn == 18) ? 32'h4000_0000 : 32'h0) | ((u & 31) << 20) | r1
                | (32'((mn == 16) ? 1 : 5) << 12) | rdv | 32'h13;
        end else if (mn == 20) begin
            bad = si < -2048 || si > 2047;
            w = (((u >> 5) & 32'h7f) << 25) | r2 | r1 | (32'd2 << 12) | ((u & 31) << 7) | 32'h23;
        end else if (mn <= 26) begin
            bad = si < -4096 || si > 4094 || (si % 2 != 0);
            w = (((u >> 12) & 1) << 31) | (((u >> 5) & 63) << 25) | r2 | r1 | (32'(f3b[mn-21]) << 12)
                | (((u >> 1) & 15) << 8) | (((u >> 11) & 1) << 7) | 32'h63;
        end else if (mn == 27) begin
            bad = si < -1048576 || si > 1048574 || (si % 2 != 0);
            w = (((u >> 20) & 1) << 31) | (((u >> 1) & 32'h3ff) << 21) | (((u >> 11) & 1) << 20)
                | (((u >> 12) & 32'hff) << 12) | rdv | 32'h6f;
        end else if (mn == 29) begin
            bad = u > 32'hfffff;
            w = ((u & 32'hfffff) << 12) | rdv | 32'h37;
        end else begin
            bad = (mn == 31);
            w = 32'h13;
        end
        e = RC && bad;
        if (e) w = 32'h13;
    endfunction

    // One cycle of stimulus; the expectation is queued only if the request was accepted.
    task automatic drive(input bit v, input int mn, input logic [4:0] rd, rs1, rs2,
                         input logic [31:0] imm, input bit ordy, input bit lit,
                         input logic [31:0] lw, input bit le, output bit acc);
        exp_t x;
        @(negedge clk);
        in_valid = v; in_mnem = 5'(mn); in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
        out_ready = ordy;
        #1;
        acc = v && in_ready && !rst;
        if (acc) begin
            if (lit) begin x.w = lw; x.e = le; end
            else model(mn, rd, rs1, rs2, imm, x.w, x.e);
            q.push_back(x);
        end
    endtask

    task automatic idle(input bit ordy);
        bit a;
        drive(0, 0, 0, 0, 0, 0, ordy, 0, 0, 0, a);
    endtask

    task automatic send(input int mn, input logic [4:0] rd, rs1, rs2, input logic [31:0] imm,
                        input logic [31:0] lw, input bit le);
        bit a;
        a = 0;
        for (int i = 0; i < 50 && !a; i++) drive(1, mn, rd, rs1, rs2, imm, 1, 1, lw, le, a);
        if (!a) begin fails++; tests++; $display("FAIL send_timeout: got 0 expected 1"); end
    endtask

    // Monitor: pops the scoreboard on every output handshake and checks hold-under-stall.
    initial begin
        bit          prev_stall;
        logic [31:0] prev_w;
        logic        prev_e;
        exp_t        x;
        prev_stall = 0; prev_w = '0; prev_e = 0;
        forever begin
            @(negedge clk); #2;
            if (rst) begin
                q.delete(); mcnt = '0; prev_stall = 0;
            end else begin
                if (prev_stall) begin
                    chk("stall_valid", 32'(out_valid), 32'd1);
                    chk("stall_word", out_instr, prev_w);
                    chk("stall_err", 32'(out_err), 32'(prev_e));
                end
                if (out_valid && out_ready) begin
                    if (q.size() == 0) begin
                        tests++; fails++;
                        $display("FAIL unexpected_out: got %08h expected none", out_instr);
                    end else begin
                        x = q.pop_front();
                        chk("word", out_instr, x.w);
                        chk("err", 32'(out_err), 32'(x.e));
                        chk("cnt", 32'(instr_cnt), 32'(mcnt));
                        mcnt = mcnt + 16'd1;
                    end
                end
                prev_stall = out_valid && !out_ready;
                prev_w = out_instr; prev_e = out_err;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    int cands[] = '{0, 1, 2, 3, 5, 31, 32, -1, -2, -4, 2046, 2047, 2048, -2048, -2049,
                    4094, 4095, 4096, -4096, -4098, 1048574, 1048575, -1048576, -1048578,
                    'h12345, 'hfffff, 'h100000};

    initial begin
        bit a;
        int acc_n;
        logic [31:0] held;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_instr", out_instr, 0);
        chk("rst_out_err", 32'(out_err), 0);
        chk("rst_cnt", 32'(instr_cnt), 0);
        @(negedge clk); rst = 0; #1;
        chk("rst_in_ready", 32'(in_ready), 1);

        // addi x1,x0,5 with 2-cycle latency
        send(10, 1, 0, 0, 5, 32'h0050_0093, 0);
        idle(1); chk("lat_c1", 32'(out_valid), 0);
        idle(1); chk("lat_c2", 32'(out_valid), 1); chk("lat_word", out_instr, 32'h0050_0093);
        idle(1); chk("cnt_after_1", 32'(instr_cnt), 1);

        // back-to-back add / srai
        send(0, 3, 1, 2, 0, 32'h0020_81B3, 0);
        send(18, 4, 4, 0, 3, 32'h4032_5213, 0);
        idle(1); chk("b2b_0", out_instr, 32'h0020_81B3);
        idle(1); chk("b2b_1", out_instr, 32'h4032_5213);

        send(20, 0, 1, 2, 8, 32'h0020_A423, 0);
        send(21, 0, 1, 2, -4, 32'hFE20_8EE3, 0);
        send(27, 1, 0, 0, 2048, 32'h0010_00EF, 0);
        send(29, 5, 0, 0, 'h12345, 32'h1234_52B7, 0);
        send(10, 1, 0, 0, 4096, RC ? 32'h13 : 32'h93, RC);
        repeat (4) idle(1);

        // stall: 3 requests offered with out_ready low for 5 cycles
        acc_n = 0;
        for (int i = 0; i < 5; i++) begin
            drive(1, 10, 5'(acc_n + 1), 0, 0, 32'(acc_n + 7), 0, 0, 0, 0, a);
            if (a) acc_n++;
        end
        chk("stall_accepted", 32'(acc_n), 2);
        chk("stall_in_ready", 32'(in_ready), 0);
        held = out_instr;
        idle(0); chk("stall_hold", out_instr, held);
        for (int i = 0; i < 20 && q.size() != 0; i++) idle(1);
        chk("stall_drain", 32'(q.size()), 0);

        // randomized traffic with random backpressure
        for (int i = 0; i < 500; i++) begin
            logic [31:0] imm;
            imm = ($urandom_range(0, 4) == 0) ? $urandom() : 32'(cands[$urandom_range(0, cands.size() - 1)]);
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 31), 5'($urandom), 5'($urandom),
                  5'($urandom), imm, $urandom_range(0, 3) != 0, 0, 0, 0, a);
        end
        for (int i = 0; i < 20 && q.size() != 0; i++) idle(1);
        chk("rand_drain", 32'(q.size()), 0);

        // reset mid-stream with pipeline full
        for (int i = 0; i < 3; i++) drive(1, 0, 1, 2, 3, 0, 0, 0, 0, 0, a);
        @(negedge clk); in_valid = 0; rst = 1;
        @(negedge clk); rst = 0; #1;
        chk("midrst_valid", 32'(out_valid), 0);
        chk("midrst_cnt", 32'(instr_cnt), 0);
        send(15, 7, 6, 0, -1, 32'hFFF3_7393, 0);
        for (int i = 0; i < 20 && q.size() != 0; i++) idle(1);
        chk("post_rst_drain", 32'(q.size()), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
